// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard.
// Combinational reads with same-cycle writeback bypass.
module reg_file_sb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_READ*AW-1:0]         ra_i,
  output logic [NUM_READ*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_READ-1:0]            rd_busy_o,
  input  logic                           we_i,
  input  logic [AW-1:0]                  wa_i,
  input  logic [DATA_WIDTH-1:0]          wd_i,
  input  logic                           issue_i,
  input  logic [AW-1:0]                  issue_addr_i,
  output logic [AW:0]                    busy_count_o
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [AW:0]           cnt;

  logic wr_en;
  logic iss_en;
  logic inc;
  logic dec;

  assign wr_en  = we_i && !(ZR && wa_i == '0);
  assign iss_en = issue_i && !(ZR && issue_addr_i == '0);

  // Same-address issue+write keeps the bit set, so no decrement then.
  always_comb begin
    inc = iss_en && !busy[issue_addr_i];
    dec = wr_en && busy[wa_i] &&
          !(iss_en && issue_addr_i == wa_i);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      busy <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) begin
        regs[wa_i] <= wd_i;
        busy[wa_i] <= 1'b0;
      end
      if (iss_en) begin
        busy[issue_addr_i] <= 1'b1;
      end
      cnt <= cnt + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
    end
  end

  assign busy_count_o = cnt;

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          zero;
    logic          byp;
    logic          wb_clr;

    assign ra     = ra_i[k*AW +: AW];
    assign zero   = ZR && ra == '0;
    assign byp    = wr_en && wa_i == ra;
    assign wb_clr = we_i && wa_i == ra &&
                    !(issue_i && issue_addr_i == ra);

    assign rd_data_o[k*DATA_WIDTH +: DATA_WIDTH] =
      zero ? '0 : (byp ? wd_i : regs[ra]);
    assign rd_busy_o[k] = !zero && busy[ra] && !wb_clr;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb against a
// behavioural register/scoreboard model.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 2;
  localparam int AW = 5;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [NP*AW-1:0] ra_i;
  logic [NP*DW-1:0] rd_data_o;
  logic [NP-1:0]    rd_busy_o;
  logic             we_i;
  logic [AW-1:0]    wa_i;
  logic [DW-1:0]    wd_i;
  logic             issue_i;
  logic [AW-1:0]    issue_addr_i;
  logic [AW:0]      busy_count_o;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] m_reg  [NR];
  bit            m_busy [NR];

  reg_file_sb #(
    .DATA_WIDTH(DW),
    .NUM_REGS(NR),
    .NUM_READ(NP),
    .ZERO_REG(1)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .ra_i(ra_i),
    .rd_data_o(rd_data_o),
    .rd_busy_o(rd_busy_o),
    .we_i(we_i),
    .wa_i(wa_i),
    .wd_i(wd_i),
    .issue_i(issue_i),
    .issue_addr_i(issue_addr_i),
    .busy_count_o(busy_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag,
                       input logic [DW-1:0] obs,
                       input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input bit rst, input bit we,
                        input int wa, input logic [DW-1:0] wd,
                        input bit iss, input int ia,
                        input int r0, input int r1);
    reset_i      = rst;
    we_i         = we;
    wa_i         = AW'(wa);
    wd_i         = wd;
    issue_i      = iss;
    issue_addr_i = AW'(ia);
    ra_i         = {AW'(r1), AW'(r0)};
  endtask

  task automatic step(input bit chk);
    int ra;
    int cnt;
    logic [DW-1:0] ed;
    bit eb;
    #2;
    if (chk) begin
      for (int k = 0; k < NP; k++) begin
        ra = int'(ra_i[k*AW +: AW]);
        if (ra == 0) begin
          ed = '0;
          eb = 1'b0;
        end else begin
          ed = (we_i && int'(wa_i) == ra) ? wd_i : m_reg[ra];
          eb = m_busy[ra] &&
               !(we_i && int'(wa_i) == ra &&
                 !(issue_i && int'(issue_addr_i) == ra));
        end
        check($sformatf("rd_data%0d@r%0d", k, ra),
              rd_data_o[k*DW +: DW], ed);
        check($sformatf("rd_busy%0d@r%0d", k, ra),
              DW'(rd_busy_o[k]), DW'(eb));
      end
      cnt = 0;
      for (int i = 0; i < NR; i++) cnt += int'(m_busy[i]);
      check("busy_count", DW'(busy_count_o), DW'(cnt));
    end
    @(posedge clk_i);
    if (reset_i) begin
      for (int i = 0; i < NR; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we_i && wa_i != 0) begin
        m_reg[wa_i]  = wd_i;
        m_busy[wa_i] = 1'b0;
      end
      if (issue_i && issue_addr_i != 0) m_busy[issue_addr_i] = 1'b1;
    end
    #1;
  endtask

  initial begin
    set_in(1, 1, 3, 32'h1234, 1, 4, 0, 0);
    @(posedge clk_i);
    #1;
    step(0);

    for (int i = 0; i < NR; i++) begin
      set_in(0, 0, 0, 0, 0, 0, i, NR - 1 - i);
      step(1);
    end

    for (int i = 1; i < NR; i++) begin
      set_in(0, 1, i, DW'(i), 0, 0, i, i);
      step(1);
    end
    for (int i = 0; i < NR; i++) begin
      set_in(0, 0, i, 100, 0, 0, i, (i + 7) % NR);
      step(1);
    end

    set_in(0, 1, 0, 1, 1, 0, 0, 0);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(1);

    set_in(0, 0, 0, 0, 1, 5, 5, 0);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 5, 5);
    step(1);
    set_in(0, 1, 5, 32'hDEAD, 0, 0, 5, 5);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 5, 0);
    step(1);

    set_in(0, 1, 7, 32'h55, 1, 7, 7, 7);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 7, 7);
    step(1);
    set_in(0, 1, 7, 32'h66, 1, 3, 7, 3);
    step(1);
    set_in(0, 0, 0, 0, 0, 0, 7, 3);
    step(1);

    for (int i = 1; i <= 4; i++) begin
      set_in(0, 0, 0, 0, 1, i, i, 0);
      step(1);
    end
    set_in(1, 1, 2, 32'hBEEF, 1, 6, 2, 1);
    step(1);
    for (int i = 0; i < 8; i++) begin
      set_in(0, 0, 0, 0, 0, 0, i, i + 8);
      step(1);
    end

    for (int n = 0; n < 400; n++) begin
      set_in($urandom_range(39) == 0,
             $urandom_range(1) == 1,
             $urandom_range(NR - 1), $urandom,
             $urandom_range(4) < 2,
             $urandom_range(NR - 1),
             $urandom_range(NR - 1),
             $urandom_range(NR - 1));
      if ($urandom_range(3) == 0) ra_i[AW-1:0] = wa_i;
      if ($urandom_range(3) == 0) ra_i[2*AW-1:AW] = issue_addr_i;
      if ($urandom_range(5) == 0) issue_addr_i = wa_i;
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, meaning register count (power of two, >=2); AW = log2(NUM_REGS).
REQ-003 SHALL have parameter NUM_READ, default 2, meaning number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero and never busy when 1.
REQ-005 SHALL have port clk_i  input  1  meaning single clock, all state updates on rising edge.
REQ-006 SHALL have port reset_i  input  1  meaning reset, synchronous and active-high.
REQ-007 SHALL have port ra_i  input  NUM_READ*AW  meaning read addresses; port k at bits [k*AW +: AW].
REQ-008 SHALL have port rd_data_o  output  NUM_READ*DATA_WIDTH  meaning read data, port k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port rd_busy_o  output  NUM_READ  meaning bit k set when port k's register awaits a pending write.
REQ-010 SHALL have port we_i  input  1  meaning writeback enable.
REQ-011 SHALL have port wa_i  input  AW  meaning writeback address.
REQ-012 SHALL have port wd_i  input  DATA_WIDTH  meaning writeback data.
REQ-013 SHALL have port issue_i  input  1  meaning mark register issue_addr_i busy (new producer in flight).
REQ-014 SHALL have port issue_addr_i  input  AW  meaning destination register of the issued producer.
REQ-015 SHALL have port busy_count_o  output  AW+1  meaning number of registers currently busy.

Function
REQ-016 Storage SHALL be NUM_REGS x DATA_WIDTH registers plus one busy bit per register.
REQ-017 Write: on rising edge with we_i=1, reg[wa_i] <= wd_i, except wa_i=0 when ZERO_REG=1 (ignored).
REQ-018 Read SHALL be combinational: rd_data_o[k] = reg[ra_i[k]].
REQ-019 Write-through bypass: if we_i=1 and ra_i[k]=wa_i (and not suppressed by REQ-017), rd_data_o[k] SHALL equal wd_i in the same cycle.
REQ-020 Read of address 0 with ZERO_REG=1 SHALL return 0 and rd_busy_o[k]=0 regardless of writes or issues.
REQ-021 Busy set: issue_i=1 sets busy[issue_addr_i] at next edge (ignored for reg 0 when ZERO_REG=1).
REQ-022 Busy clear: we_i=1 clears busy[wa_i] at next edge.
REQ-023 Same-cycle issue and write to the same address: busy SHALL end set (new producer wins), data still written.
REQ-024 Issue to an already-busy register SHALL leave it busy (no counting of multiple producers).
REQ-025 Write to a non-busy register SHALL update data and leave busy clear.
REQ-026 rd_busy_o[k] = busy[ra_i[k]] AND NOT (we_i=1 AND wa_i=ra_i[k] AND NOT (issue_i=1 AND issue_addr_i=ra_i[k])); i.e. writeback bypass also clears busy combinationally.
REQ-027 busy_count_o SHALL be a registered counter: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both occur on different addresses in one cycle; never exceeds NUM_REGS-ZERO_REG.
REQ-028 Latency: write visible on read ports same cycle (bypass) and from storage the cycle after; busy set visible the cycle after issue.

Reset
REQ-029 reset_i=1 at a rising edge SHALL clear all registers to 0, all busy bits to 0, busy_count_o to 0.
REQ-030 reset_i SHALL take priority over same-cycle we_i and issue_i; reset mid-operation discards them.
REQ-031 Outputs SHALL be combinationally 0 for data/busy on all ports in the cycle after reset for any address.

Verification
REQ-032 Reset, sweep all addresses on every read port -> rd_data_o=0, rd_busy_o=0, busy_count_o=0.
REQ-033 Write reg i=i for i=1..31 with ra_i=wa_i -> bypass returns i same cycle; after, we_i=0, wd_i=100 sweep -> data still i.
REQ-034 we_i=1, wa_i=0, wd_i=1 with ZERO_REG=1 -> read 0 returns 0; issue_addr_i=0 -> busy_count_o stays 0.
REQ-035 issue r5, next cycle read r5 -> rd_busy_o=1, busy_count_o=1; writeback r5=0xDEAD -> same cycle rd_busy_o=0, data 0xDEAD; next cycle busy_count_o=0.
REQ-036 Same cycle issue r7 and writeback r7=0x55 -> next cycle data 0x55, busy=1, busy_count_o=1; same cycle issue r3 + writeback r7 -> count stays 1.
REQ-037 Issue r1..r4 then assert reset_i with we_i=1, wa_i=2 -> next cycle all data 0, busy_count_o=0.
